cursor_select_ctrl: RTL and testbench

- Consumes the one-cycle keyboard operation pulses produced by the PS/2 decoder stage (select, left, right, up, down).
- Maintains a cursor on a COLS x ROWS game board and tracks a two-cell selection.
- Issues a swap request to the game-logic stage over a valid/ready handshake when two orthogonally adjacent cells are chosen.
- Sits between the PS/2 decoder and the board/game engine; also drives cursor/selection highlight coordinates for the display path.

---
 rtl/game_pkg.sv | 29 ++
 rtl/cursor_axis.sv | 44 ++++
 rtl/cursor_select_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_cursor_select_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared definitions for the keyboard-driven board game:
//                operation pulse bit indices, cursor/selection FSM states and
//                default board dimensions.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Bit positions inside the operation pulse vector from the PS/2 decoder
    localparam int OP_SEL   = 0;
    localparam int OP_LEFT  = 1;
    localparam int OP_RIGHT = 2;
    localparam int OP_UP    = 3;
    localparam int OP_DOWN  = 4;

    // Default board size, shared with the board engine and display path
    localparam int DEF_COLS = 8;
    localparam int DEF_ROWS = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECTED = 2'd1,
        REQ      = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cursor_axis.sv
`default_nettype none
// ============================================================================
//  Module      : cursor_axis
//  Description : One axis of the board cursor. Bounded up/down counter over
//                0..SIZE-1 that either saturates at the edges or wraps to the
//                opposite edge. inc and dec are never asserted together by the
//                parent; dec wins if they ever are.
//  Revision    : 1.0 - initial release
// ============================================================================
module cursor_axis #(
    parameter int SIZE = 8,
    parameter int WRAP = 0,
    parameter int W    = $clog2(SIZE)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] pos
);

    localparam logic [W-1:0] MAX_POS = W'(SIZE - 1);
    localparam logic [W-1:0] ONE     = W'(1);

    // Position register; edges are tested explicitly so non-power-of-two
    // sizes never step outside the board
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
        end else if (dec) begin
            if (pos == '0)
                pos <= (WRAP != 0) ? MAX_POS : '0;
            else
                pos <= pos - ONE;
        end else if (inc) begin
            if (pos == MAX_POS)
                pos <= (WRAP != 0) ? '0 : MAX_POS;
            else
                pos <= pos + ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cursor_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cursor_select_ctrl
//  Description : Cursor and two-cell selection controller. Turns keyboard
//                operation pulses into cursor movement, tracks a first
//                selected cell and issues a swap request (valid/ready) when a
//                second, orthogonally adjacent cell is confirmed.
//  Revision    : 1.0 - initial release
// ============================================================================
module cursor_select_ctrl
    import game_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    parameter int WRAP = 0,
    parameter int XW   = $clog2(COLS),
    parameter int YW   = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    operation,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          sel_valid,
    output logic [XW-1:0] sel_x,
    output logic [YW-1:0] sel_y,
    output logic          req_valid,
    output logic [XW-1:0] req_ax,
    output logic [YW-1:0] req_ay,
    output logic [XW-1:0] req_bx,
    output logic [YW-1:0] req_by,
    input  logic          req_ready
);

    localparam logic [XW-1:0] ONE_X = XW'(1);
    localparam logic [YW-1:0] ONE_Y = YW'(1);

    state_t          state;
    state_t          state_nxt;
    logic            sel_valid_nxt;
    logic [XW-1:0]   sel_x_nxt;
    logic [YW-1:0]   sel_y_nxt;
    logic            req_valid_nxt;
    logic [XW-1:0]   req_ax_nxt;
    logic [YW-1:0]   req_ay_nxt;
    logic [XW-1:0]   req_bx_nxt;
    logic [YW-1:0]   req_by_nxt;

    logic            move_en;
    logic            go_left;
    logic            go_right;
    logic            go_up;
    logic            go_down;
    logic            do_select;
    logic [XW-1:0]   dx;
    logic [YW-1:0]   dy;
    logic            same_cell;
    logic            adjacent;

    // Priority arbitration: select > left > right > up > down; everything is
    // ignored while a request is outstanding
    always_comb begin
        do_select = (state != REQ) && operation[OP_SEL];
        move_en   = (state != REQ) && !operation[OP_SEL];
        go_left   = move_en && operation[OP_LEFT];
        go_right  = move_en && !operation[OP_LEFT] && operation[OP_RIGHT];
        go_up     = move_en && !operation[OP_LEFT] && !operation[OP_RIGHT]
                    && operation[OP_UP];
        go_down   = move_en && !operation[OP_LEFT] && !operation[OP_RIGHT]
                    && !operation[OP_UP] && operation[OP_DOWN];
    end

    // Absolute cursor-to-selection distance per axis; no wrap-around, so
    // opposite edges are never considered adjacent
    always_comb begin
        dx        = (cur_x >= sel_x) ? (cur_x - sel_x) : (sel_x - cur_x);
        dy        = (cur_y >= sel_y) ? (cur_y - sel_y) : (sel_y - cur_y);
        same_cell = (dx == '0) && (dy == '0);
        adjacent  = ((dx == ONE_X) && (dy == '0)) ||
                    ((dx == '0) && (dy == ONE_Y));
    end

    cursor_axis #(
        .SIZE (COLS),
        .WRAP (WRAP),
        .W    (XW)
    ) u_axis_x (
        .clk  (clk),
        .rst  (rst),
        .inc  (go_right),
        .dec  (go_left),
        .pos  (cur_x)
    );

    cursor_axis #(
        .SIZE (ROWS),
        .WRAP (WRAP),
        .W    (YW)
    ) u_axis_y (
        .clk  (clk),
        .rst  (rst),
        .inc  (go_down),
        .dec  (go_up),
        .pos  (cur_y)
    );

    // Next-state and next-output logic for the selection/request FSM
    always_comb begin
        state_nxt     = state;
        sel_valid_nxt = sel_valid;
        sel_x_nxt     = sel_x;
        sel_y_nxt     = sel_y;
        req_valid_nxt = req_valid;
        req_ax_nxt    = req_ax;
        req_ay_nxt    = req_ay;
        req_bx_nxt    = req_bx;
        req_by_nxt    = req_by;
        case (state)
            IDLE: begin
                if (do_select) begin
                    sel_x_nxt     = cur_x;
                    sel_y_nxt     = cur_y;
                    sel_valid_nxt = 1'b1;
                    state_nxt     = SELECTED;
                end
            end
            SELECTED: begin
                if (do_select) begin
                    if (same_cell) begin
                        sel_valid_nxt = 1'b0;
                        state_nxt     = IDLE;
                    end else if (adjacent) begin
                        req_ax_nxt    = sel_x;
                        req_ay_nxt    = sel_y;
                        req_bx_nxt    = cur_x;
                        req_by_nxt    = cur_y;
                        req_valid_nxt = 1'b1;
                        state_nxt     = REQ;
                    end else begin
                        sel_x_nxt     = cur_x;
                        sel_y_nxt     = cur_y;
                    end
                end
            end
            REQ: begin
                if (req_ready) begin
                    req_valid_nxt = 1'b0;
                    sel_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt     = IDLE;
                sel_valid_nxt = 1'b0;
                req_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset drops any pending request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel_valid <= 1'b0;
            sel_x     <= '0;
            sel_y     <= '0;
            req_valid <= 1'b0;
            req_ax    <= '0;
            req_ay    <= '0;
            req_bx    <= '0;
            req_by    <= '0;
        end else begin
            state     <= state_nxt;
            sel_valid <= sel_valid_nxt;
            sel_x     <= sel_x_nxt;
            sel_y     <= sel_y_nxt;
            req_valid <= req_valid_nxt;
            req_ax    <= req_ax_nxt;
            req_ay    <= req_ay_nxt;
            req_bx    <= req_bx_nxt;
            req_by    <= req_by_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cursor_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cursor_select_ctrl
//  Description : Directed self-checking bench for cursor_select_ctrl. Instance
//                a is an 8x8 saturating board, instance b a 6x8 wrapping one.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cursor_select_ctrl;

    localparam logic [4:0] OP_NONE  = 5'b00000;
    localparam logic [4:0] OP_SEL   = 5'b00001;
    localparam logic [4:0] OP_LEFT  = 5'b00010;
    localparam logic [4:0] OP_RIGHT = 5'b00100;
    localparam logic [4:0] OP_UP    = 5'b01000;
    localparam logic [4:0] OP_DOWN  = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] op_a = '0;
    logic [4:0] op_b = '0;
    logic       ready_a = 1'b0;
    logic       ready_b = 1'b0;

    logic [2:0] a_cur_x, a_sel_x, a_req_ax, a_req_bx;
    logic [2:0] a_cur_y, a_sel_y, a_req_ay, a_req_by;
    logic       a_sel_valid, a_req_valid;
    logic [2:0] b_cur_x, b_sel_x, b_req_ax, b_req_bx;
    logic [2:0] b_cur_y, b_sel_y, b_req_ay, b_req_by;
    logic       b_sel_valid, b_req_valid;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cursor_select_ctrl #(.COLS(8), .ROWS(8), .WRAP(0)) dut_a (
        .clk(clk), .rst(rst), .operation(op_a),
        .cur_x(a_cur_x), .cur_y(a_cur_y),
        .sel_valid(a_sel_valid), .sel_x(a_sel_x), .sel_y(a_sel_y),
        .req_valid(a_req_valid), .req_ax(a_req_ax), .req_ay(a_req_ay),
        .req_bx(a_req_bx), .req_by(a_req_by), .req_ready(ready_a)
    );

    cursor_select_ctrl #(.COLS(6), .ROWS(8), .WRAP(1)) dut_b (
        .clk(clk), .rst(rst), .operation(op_b),
        .cur_x(b_cur_x), .cur_y(b_cur_y),
        .sel_valid(b_sel_valid), .sel_x(b_sel_x), .sel_y(b_sel_y),
        .req_valid(b_req_valid), .req_ax(b_req_ax), .req_ay(b_req_ay),
        .req_bx(b_req_bx), .req_by(b_req_by), .req_ready(ready_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Called on a negedge: present one pulse per instance for one clock edge
    task automatic step(input logic [4:0] a, input logic [4:0] b);
        op_a = a;
        op_b = b;
        @(negedge clk);
        op_a = OP_NONE;
        op_b = OP_NONE;
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        check("rst_cur_x", a_cur_x, 0);
        check("rst_cur_y", a_cur_y, 0);
        check("rst_sel_valid", a_sel_valid, 0);
        check("rst_req_valid", a_req_valid, 0);
        check("rst_req_bx", a_req_bx, 0);
        rst = 1'b0;
        @(negedge clk);

        // Movement: right x3, down x2 -> (3,2); wrap instance left/right/up
        step(OP_RIGHT, OP_LEFT);
        check("b_wrap_left_x", b_cur_x, 5);
        step(OP_RIGHT, OP_RIGHT);
        check("b_wrap_right_x", b_cur_x, 0);
        step(OP_RIGHT, OP_UP);
        check("b_wrap_up_y", b_cur_y, 7);
        step(OP_DOWN, OP_LEFT);
        step(OP_DOWN, OP_NONE);
        check("move_x", a_cur_x, 3);
        check("move_y", a_cur_y, 2);
        check("b_hold_x", b_cur_x, 5);

        // Saturation at x = 0
        repeat (5) step(OP_LEFT, OP_NONE);
        check("sat_x", a_cur_x, 0);
        check("sat_y", a_cur_y, 2);
        repeat (2) step(OP_RIGHT, OP_NONE);
        check("at22_x", a_cur_x, 2);

        // Select then cancel on the same cell
        step(OP_SEL, OP_NONE);
        check("sel1_valid", a_sel_valid, 1);
        check("sel1_x", a_sel_x, 2);
        check("sel1_y", a_sel_y, 2);
        step(OP_SEL, OP_NONE);
        check("cancel_valid", a_sel_valid, 0);
        check("cancel_req", a_req_valid, 0);

        // Adjacent pair -> request a=(2,2) b=(3,2)
        step(OP_SEL, OP_NONE);
        step(OP_RIGHT, OP_NONE);
        step(OP_SEL, OP_NONE);
        check("req_valid", a_req_valid, 1);
        check("req_ax", a_req_ax, 2);
        check("req_ay", a_req_ay, 2);
        check("req_bx", a_req_bx, 3);
        check("req_by", a_req_by, 2);
        check("req_sel_valid", a_sel_valid, 1);

        // Held while not ready; movement ignored
        for (int i = 0; i < 10; i++) begin
            step((i % 2 == 0) ? OP_LEFT : OP_UP, OP_NONE);
            check("hold_valid", a_req_valid, 1);
            check("hold_cur", {a_cur_x, a_cur_y}, {3'd3, 3'd2});
            check("hold_req", {a_req_ax, a_req_ay, a_req_bx, a_req_by},
                  {3'd2, 3'd2, 3'd3, 3'd2});
        end

        // Accept
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        check("acc_req_valid", a_req_valid, 0);
        check("acc_sel_valid", a_sel_valid, 0);
        check("acc_cur", {a_cur_x, a_cur_y}, {3'd3, 3'd2});

        // Non-adjacent re-latch: select (1,1), move to (3,1), select
        step(OP_LEFT, OP_NONE);
        step(OP_LEFT, OP_NONE);
        step(OP_UP, OP_NONE);
        step(OP_SEL, OP_NONE);
        check("s11", {a_sel_x, a_sel_y}, {3'd1, 3'd1});
        step(OP_RIGHT, OP_NONE);
        step(OP_RIGHT, OP_NONE);
        step(OP_SEL, OP_NONE);
        check("relatch_sel", {a_sel_x, a_sel_y}, {3'd3, 3'd1});
        check("relatch_valid", a_sel_valid, 1);
        check("relatch_noreq", a_req_valid, 0);

        // Left and right together -> left only
        step(5'b00110, OP_NONE);
        check("prio_lr_x", a_cur_x, 2);

        // Select with left in the same cycle -> select wins, adjacent request
        step(5'b00011, OP_NONE);
        check("prio_sel_x", a_cur_x, 2);
        check("prio_req_valid", a_req_valid, 1);
        check("prio_req_a", {a_req_ax, a_req_ay}, {3'd3, 3'd1});
        check("prio_req_b", {a_req_bx, a_req_by}, {3'd2, 3'd1});

        // Asynchronous reset while the request is pending
        #2 rst = 1'b1;
        #1;
        check("arst_req_valid", a_req_valid, 0);
        check("arst_sel_valid", a_sel_valid, 0);
        check("arst_cur", {a_cur_x, a_cur_y}, 0);
        check("arst_req", {a_req_ax, a_req_ay, a_req_bx, a_req_by}, 0);
        check("arst_b_cur", {b_cur_x, b_cur_y}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
